// File: rtl/rotate_result_queue.sv
// rotate_result_queue
//
// Purpose:
//   Registered front end for the 8-bit left-rotate datapath. Each accepted
//   operand/amount pair is rotated left on the accept edge. The result and
//   its flags go into a DEPTH-entry circular FIFO, which a downstream
//   valid/ready consumer drains. This decouples ALU issue from writeback.
//
// Optional feature macro: ROTQ_PARITY_EN
//   defined   : each entry also stores parity = ^result, shown on out_parity
//   undefined : no parity bit is stored and out_parity is tied to 0
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   request present
//   in_ready   out  queue can accept this cycle (count < DEPTH)
//   in_a       in   [7:0] operand to rotate
//   in_amt     in   [2:0] left-rotate amount
//   out_valid  out  head entry present (count != 0)
//   out_ready  in   consumer takes head this cycle
//   out_result out  [7:0] rotated value at head, 0 when empty
//   out_zero   out  head result == 0, 0 when empty
//   out_carry  out  bit wrapped into bit 0 (0 for amount 0), 0 when empty
//   out_parity out  head parity (ROTQ_PARITY_EN only), else 0
//   count      out  [log2(DEPTH):0] occupied entries
module rotate_result_queue #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [7:0]                 in_a,
    input  logic [2:0]                 in_amt,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [7:0]                 out_result,
    output logic                       out_zero,
    output logic                       out_carry,
    output logic                       out_parity,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

`ifdef ROTQ_PARITY_EN
    localparam int EW = 11;   // {parity, carry, zero, result}
`else
    localparam int EW = 10;   // {carry, zero, result}
`endif

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic [EW-1:0] mem_q [DEPTH];

    logic          push;
    logic          pop;
    logic [7:0]    rot_s4;
    logic [7:0]    rot_s2;
    logic [7:0]    rot_s1;
    logic          rot_zero;
    logic          rot_carry;
    logic [EW-1:0] entry_d;
    logic [EW-1:0] head;

    // Handshake decode. Both sides look only at registered occupancy, so
    // there is no combinational path from out_ready to in_ready.
    assign in_ready  = (count_q < CW'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Rotator: 4/2/1 mux cascade, each stage selected by one amount bit.
    assign rot_s4 = in_amt[2] ? {in_a[3:0],   in_a[7:4]}   : in_a;
    assign rot_s2 = in_amt[1] ? {rot_s4[5:0], rot_s4[7:6]} : rot_s4;
    assign rot_s1 = in_amt[0] ? {rot_s2[6:0], rot_s2[7]}   : rot_s2;

    assign rot_zero  = ~|rot_s1;
    // Bit 0 of a left rotate is the bit that wrapped around, unless nothing moved.
    assign rot_carry = (in_amt != 3'd0) ? rot_s1[0] : 1'b0;

`ifdef ROTQ_PARITY_EN
    assign entry_d = {^rot_s1, rot_carry, rot_zero, rot_s1};
`else
    assign entry_d = {rot_carry, rot_zero, rot_s1};
`endif

    // Pointer and occupancy next state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the empty-forcing below hides stale contents.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= entry_d;
        end
    end

    // Head is forced to zero when empty so stale data never leaks out.
    assign head       = out_valid ? mem_q[rd_ptr_q] : '0;
    assign out_result = head[7:0];
    assign out_zero   = head[8];
    assign out_carry  = head[9];
`ifdef ROTQ_PARITY_EN
    assign out_parity = head[10];
`else
    assign out_parity = 1'b0;
`endif
    assign count      = count_q;

endmodule

// File: tb/tb_rotate_result_queue.sv
module tb_rotate_result_queue;

    localparam int DEPTH = 4;
`ifdef ROTQ_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_a = 8'h00;
    logic [2:0] in_amt = 3'd0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_result;
    logic       out_zero;
    logic       out_carry;
    logic       out_parity;
    logic [2:0] count;

    int total = 0;
    int bad = 0;

    typedef struct packed {
        logic [7:0] r;
        logic       z;
        logic       c;
        logic       p;
    } ent_t;

    ent_t mq[$];

    rotate_result_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_amt(in_amt),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_zero(out_zero),
        .out_carry(out_carry), .out_parity(out_parity),
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference rotate straight from the arithmetic definition.
    function automatic ent_t model_ent(input logic [7:0] a, input logic [2:0] amt);
        ent_t e;
        logic [15:0] dbl;
        dbl  = {a, a} >> (8 - int'(amt));
        e.r  = dbl[7:0];
        e.z  = (e.r == 8'h00);
        e.c  = (amt != 3'd0) ? e.r[0] : 1'b0;
        e.p  = PAR_EN ? ^e.r : 1'b0;
        return e;
    endfunction

    // Reference queue update on each clock edge.
    always @(posedge clk) begin
        if (rst_n) begin
            bit do_push, do_pop;
            do_push = in_valid && (mq.size() < DEPTH);
            do_pop  = out_ready && (mq.size() > 0);
            if (do_pop) void'(mq.pop_front());
            if (do_push) mq.push_back(model_ent(in_a, in_amt));
        end
    end

    always @(negedge rst_n) mq.delete();

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        ent_t h;
        logic ev;
        ev = (mq.size() != 0);
        h  = ev ? mq[0] : '0;
        chk("out_valid", 32'(out_valid), 32'(ev));
        chk("in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
        chk("count", 32'(count), 32'(mq.size()));
        chk("out_result", 32'(out_result), 32'(h.r));
        chk("out_zero", 32'(out_zero), 32'(h.z));
        chk("out_carry", 32'(out_carry), 32'(h.c));
        chk("out_parity", 32'(out_parity), 32'(h.p));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Push one entry with the consumer stalled, then check the head literally.
    task automatic push_check(input logic [7:0] a, input logic [2:0] amt,
                              input logic [7:0] er, input logic ez, input logic ec);
        in_valid = 1'b1; in_a = a; in_amt = amt; out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        chk("lit_valid", 32'(out_valid), 32'd1);
        chk("lit_result", 32'(out_result), 32'(er));
        chk("lit_zero", 32'(out_zero), 32'(ez));
        chk("lit_carry", 32'(out_carry), 32'(ec));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        // Reset / idle
        #12;
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_result", 32'(out_result), 32'd0);
        chk("rst_flags", 32'({out_zero, out_carry, out_parity}), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        step();

        // Single push and amount edges
        push_check(8'h81, 3'd1, 8'h03, 1'b0, 1'b1);
        chk("lit_parity_81", 32'(out_parity), 32'd0);
        push_check(8'hF0, 3'd4, 8'h0F, 1'b0, 1'b1);
        push_check(8'h00, 3'd0, 8'h00, 1'b1, 1'b0);
        push_check(8'h01, 3'd7, 8'h80, 1'b0, 1'b0);

        // Fill to full, fifth push dropped
        for (int i = 1; i <= 5; i++) begin
            in_valid = 1'b1; in_a = 8'(i); in_amt = 3'd0;
            step();
            if (i == 4) begin
                chk("full_ready", 32'(in_ready), 32'd0);
                chk("full_count", 32'(count), 32'd4);
            end
        end
        in_valid = 1'b0;
        chk("full_count_after5", 32'(count), 32'd4);
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk("drain_order", 32'(out_result), 32'(i));
            step();
        end
        out_ready = 1'b0;
        chk("drain_empty", 32'(count), 32'd0);

        // Simultaneous push/pop at count = 2
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_a = 8'($urandom); in_amt = 3'($urandom);
            step();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_a = 8'($urandom); in_amt = 3'($urandom);
            step();
            chk("pp_count", 32'(count), 32'd2);
        end
        in_valid = 1'b0;
        step(); step();
        out_ready = 1'b0;

        // Mid-stream asynchronous reset at count = 3
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_a = 8'hA0 + 8'(i); in_amt = 3'd0;
            step();
        end
        in_valid = 1'b0;
        chk("pre_rst_count", 32'(count), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_ready", 32'(in_ready), 32'd1);
        chk("arst_result", 32'(out_result), 32'd0);
        chk("arst_count", 32'(count), 32'd0);
        step();
        rst_n = 1'b1;
        in_valid = 1'b1; in_a = 8'h5A; in_amt = 3'd0;
        step();
        in_valid = 1'b0;
        chk("post_rst_head", 32'(out_result), 32'h5A);
        chk("post_rst_count", 32'(count), 32'd1);
        out_ready = 1'b1;
        step();
        chk("post_rst_no_old", 32'(out_valid), 32'd0);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            in_valid  = 1'($urandom_range(0, 3) != 0);
            out_ready = 1'($urandom_range(0, 2) != 0);
            in_a      = 8'($urandom);
            in_amt    = 3'($urandom);
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (DEPTH + 1) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
